l2_port_arbiter: RTL and testbench
==================================

Name: l2_port_arbiter

Overview:
- Clocked arbiter that shares the single L2 port between the two L1 caches (core A and core B).
- Replaces fixed A-over-B combinational priority with round-robin grants that are held for a whole transaction.
- Each request is latched and issued to L2 as a one-cycle request.
- Waits out L2 busy, returns read data and a done pulse to the owner, and broadcasts snoop pulses to the other L1 for coherence.

Parameters:
- n, 32, data word width
- AW, 10, word address width

Ports:
- clock  input  1  system clock
- nreset  input  1  synchronous active-low reset
- l1a_read_req, l1b_read_req  input  1 each  read request, held until matching done
- l1a_write_req, l1b_write_req  input  1 each  write request, held until matching done
- l1a_addr, l1b_addr  input  AW each  word address, stable while request held
- l1a_wdata, l1b_wdata  input  n each  write data, stable while request held
- l2_busy_in  input  1  L2 busy
- l2_rdata_in  input  n  read data from L2, valid in the cycle busy is low in WAIT
- l2_read_request, l2_write_request  output  1 each  one-cycle request to L2
- l2_addr  output  AW  latched address
- l2_wdata  output  n  latched write data
- l1a_rdata, l1b_rdata  output  n each  registered read data
- l1a_done, l1b_done  output  1 each  one-cycle completion pulse
- l2_busy_out_a, l2_busy_out_b  output  1 each  arbiter occupied
- snoop_read_a, snoop_read_b  output  1 each  other core issued a read (pulse)
- snoop_write_a, snoop_write_b  output  1 each  other core issued a write (pulse)

Behaviour:
- Reset (nreset=0 at clock edge):
  - state=IDLE, owner=A, priority pointer=A.
  - All outputs 0, including address, data and rdata registers.
  - Reset mid-transaction abandons it; no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - A core is pending if its read_req or its write_req is high.
  - If only one core is pending, grant it.
  - If both are pending, grant the pointer side.
  - On grant: latch owner, op, addr and wdata, then go to ISSUE.
  - If a core has read and write high together, treat it as a write.
- ISSUE (exactly 1 cycle):
  - l2_read_request or l2_write_request = 1 per the latched op.
  - The other core's snoop_read_x or snoop_write_x pulses high.
  - Next state: WAIT.
- WAIT:
  - Stay while l2_busy_in=1.
  - On the first cycle with l2_busy_in=0: capture l2_rdata_in into the owner's rdata register (reads only), then go to DONE.
  - Minimum latency from grant to done is 3 cycles: ISSUE, WAIT, DONE.
- DONE (1 cycle):
  - Owner's done pulses high.
  - Pointer flips to the non-owner.
  - Next state: IDLE.
  - Both cores get at least one IDLE cycle before the next grant.
- l2_busy_out_a = l2_busy_out_b = (state != IDLE).
- l2_addr and l2_wdata hold their latched values until the next grant.
- A request dropped early by the L1 has no effect after grant; the transaction completes anyway.
- The non-owner's rdata register is never modified.
- Starvation bound: a held request is granted within one foreign transaction.

Optional Feature:
- Macro: L2ARB_PERF_EN.
- When defined, adds the following outputs:
  - grant_cnt_a, grant_cnt_b: 16-bit each, incremented on entry to ISSUE for that core.
  - contention_cnt: 16-bit, incremented on every IDLE grant where both cores were pending.
  - All three wrap at 0xFFFF→0 and are cleared by reset.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package l2_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT, DONE}
  - typedef enum core_id_t {CORE_A, CORE_B}
  - typedef enum op_t {OP_READ, OP_WRITE}
  - localparam for the counter width (16)
- One natural sub-module, rr_pick2: a combinational 2-way round-robin picker with inputs pending[1:0] and ptr, and outputs grant_valid and grant_id.
- The FSM and datapath stay in the top module.

Test Plan:
1. Reset hold, then release with no requests → all outputs 0, busy_out low, state IDLE for 10 cycles.
2. A reads addr 0x005, L2 busy for 2 cycles, l2_rdata_in=0xDEADBEEF → l2_read_request 1 cycle with l2_addr=0x005, snoop_read_b pulse, l1a_rdata=0xDEADBEEF, l1a_done pulse 5 cycles after grant; l1b_rdata unchanged.
3. A and B both write in the same cycle, A wdata 0x11 addr 0x001, B wdata 0x22 addr 0x002 → A granted first (pointer=A after reset), then B; two write pulses in order A, B; snoop_write_b then snoop_write_a; each done pulse exactly once.
4. B holds read and write high together → treated as a write: l2_write_request, snoop_write_a.
5. nreset asserted while in WAIT → next cycle state IDLE, no done pulse, pointer=A; a subsequent B request is granted normally.
6. With L2ARB_PERF_EN defined: 3 contended rounds → grant_cnt_a=3, grant_cnt_b=3, contention_cnt ≥ 3. With the counter preloaded to 0xFFFF via force, one more grant → it reads 0.

Source files
------------

// File: rtl/l2_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_arb_pkg
// Description : Shared types and constants for the L2 port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        CORE_A = 1'b0,
        CORE_B = 1'b1
    } core_id_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int c_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/l2_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : l2_port_arbiter_if
// Description : L1-side request/response and L2-side port signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface l2_port_arbiter_if #(
    parameter int N  = 32,
    parameter int AW = 10
);
    logic          l1a_read_req;
    logic          l1b_read_req;
    logic          l1a_write_req;
    logic          l1b_write_req;
    logic [AW-1:0] l1a_addr;
    logic [AW-1:0] l1b_addr;
    logic [N-1:0]  l1a_wdata;
    logic [N-1:0]  l1b_wdata;
    logic          l2_busy_in;
    logic [N-1:0]  l2_rdata_in;

    logic          l2_read_request;
    logic          l2_write_request;
    logic [AW-1:0] l2_addr;
    logic [N-1:0]  l2_wdata;
    logic [N-1:0]  l1a_rdata;
    logic [N-1:0]  l1b_rdata;
    logic          l1a_done;
    logic          l1b_done;
    logic          l2_busy_out_a;
    logic          l2_busy_out_b;
    logic          snoop_read_a;
    logic          snoop_read_b;
    logic          snoop_write_a;
    logic          snoop_write_b;

    // Arbiter side
    modport slave (
        input  l1a_read_req, l1b_read_req, l1a_write_req, l1b_write_req,
               l1a_addr, l1b_addr, l1a_wdata, l1b_wdata, l2_busy_in, l2_rdata_in,
        output l2_read_request, l2_write_request, l2_addr, l2_wdata,
               l1a_rdata, l1b_rdata, l1a_done, l1b_done,
               l2_busy_out_a, l2_busy_out_b,
               snoop_read_a, snoop_read_b, snoop_write_a, snoop_write_b
    );

    // L1/L2 environment side
    modport master (
        output l1a_read_req, l1b_read_req, l1a_write_req, l1b_write_req,
               l1a_addr, l1b_addr, l1a_wdata, l1b_wdata, l2_busy_in, l2_rdata_in,
        input  l2_read_request, l2_write_request, l2_addr, l2_wdata,
               l1a_rdata, l1b_rdata, l1a_done, l1b_done,
               l2_busy_out_a, l2_busy_out_b,
               snoop_read_a, snoop_read_b, snoop_write_a, snoop_write_b
    );

endinterface
`default_nettype wire

// File: rtl/l2_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin picker; the pointer wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import l2_arb_pkg::*;
(
    input  wire logic [1:0] i_pending,
    input  core_id_t        i_ptr,
    output logic            o_grant_valid,
    output core_id_t        o_grant_id
);

    always_comb begin
        o_grant_valid = |i_pending;
        case (i_pending)
            2'b01:   o_grant_id = CORE_A;
            2'b10:   o_grant_id = CORE_B;
            default: o_grant_id = i_ptr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2_port_arbiter
// Description : Round-robin sharing of one L2 port between two L1 caches, with
//               whole-transaction grants, snoop broadcast and done pulses.
//               Optional perf counters enabled by macro L2ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 10
) (
    input  wire logic        clock,
    input  wire logic        nreset,
    l2_port_arbiter_if.slave bus
`ifdef L2ARB_PERF_EN
    ,
    output logic [c_CNT_W-1:0] grant_cnt_a,
    output logic [c_CNT_W-1:0] grant_cnt_b,
    output logic [c_CNT_W-1:0] contention_cnt
`endif
);

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    core_id_t      r_owner;
    core_id_t      r_ptr;
    op_t           r_op;
    logic [AW-1:0] r_addr;
    logic [N-1:0]  r_wdata;
    logic [N-1:0]  r_rdata_a;
    logic [N-1:0]  r_rdata_b;

    logic [1:0]    w_pending;
    logic          w_grant_valid;
    core_id_t      w_grant_id;
    logic          w_grant;
    op_t           w_grant_op;
    logic          w_capture;

    assign w_pending = {bus.l1b_read_req | bus.l1b_write_req,
                        bus.l1a_read_req | bus.l1a_write_req};

    rr_pick2 u_pick (
        .i_pending     (w_pending),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    assign w_grant = (r_state == IDLE) && w_grant_valid;
    // A simultaneous read+write from one core resolves to a write
    assign w_grant_op = ((w_grant_id == CORE_A) ? bus.l1a_write_req : bus.l1b_write_req)
                        ? OP_WRITE : OP_READ;
    assign w_capture = (r_state == WAIT) && !bus.l2_busy_in && (r_op == OP_READ);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (!bus.l2_busy_in) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_owner   <= CORE_A;
            r_ptr     <= CORE_A;
            r_op      <= OP_READ;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_grant_id;
                r_op    <= w_grant_op;
                r_addr  <= (w_grant_id == CORE_A) ? bus.l1a_addr  : bus.l1b_addr;
                r_wdata <= (w_grant_id == CORE_A) ? bus.l1a_wdata : bus.l1b_wdata;
            end
            if (w_capture && (r_owner == CORE_A)) r_rdata_a <= bus.l2_rdata_in;
            if (w_capture && (r_owner == CORE_B)) r_rdata_b <= bus.l2_rdata_in;
            if (r_state == DONE) r_ptr <= (r_owner == CORE_A) ? CORE_B : CORE_A;
        end
    end

    always_comb begin
        bus.l2_read_request  = (r_state == ISSUE) && (r_op == OP_READ);
        bus.l2_write_request = (r_state == ISSUE) && (r_op == OP_WRITE);
        // Snoops go to the core that does not own the transaction
        bus.snoop_read_a     = bus.l2_read_request  && (r_owner == CORE_B);
        bus.snoop_write_a    = bus.l2_write_request && (r_owner == CORE_B);
        bus.snoop_read_b     = bus.l2_read_request  && (r_owner == CORE_A);
        bus.snoop_write_b    = bus.l2_write_request && (r_owner == CORE_A);
        bus.l1a_done         = (r_state == DONE) && (r_owner == CORE_A);
        bus.l1b_done         = (r_state == DONE) && (r_owner == CORE_B);
        bus.l2_busy_out_a    = (r_state != IDLE);
        bus.l2_busy_out_b    = (r_state != IDLE);
        bus.l2_addr          = r_addr;
        bus.l2_wdata         = r_wdata;
        bus.l1a_rdata        = r_rdata_a;
        bus.l1b_rdata        = r_rdata_b;
    end

`ifdef L2ARB_PERF_EN
    logic [c_CNT_W-1:0] r_grant_cnt_a;
    logic [c_CNT_W-1:0] r_grant_cnt_b;
    logic [c_CNT_W-1:0] r_contention_cnt;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_grant_cnt_a    <= '0;
            r_grant_cnt_b    <= '0;
            r_contention_cnt <= '0;
        end else begin
            if (w_grant && (w_grant_id == CORE_A)) r_grant_cnt_a <= r_grant_cnt_a + 1'b1;
            if (w_grant && (w_grant_id == CORE_B)) r_grant_cnt_b <= r_grant_cnt_b + 1'b1;
            if (w_grant && (&w_pending))           r_contention_cnt <= r_contention_cnt + 1'b1;
        end
    end

    assign grant_cnt_a    = r_grant_cnt_a;
    assign grant_cnt_b    = r_grant_cnt_b;
    assign contention_cnt = r_contention_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_port_arbiter
// Description : Table-driven, scoreboarded bench for l2_port_arbiter
//               (perf counter checks built when L2ARB_PERF_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_l2_port_arbiter;
    import l2_arb_pkg::*;

    localparam int N  = 32;
    localparam int AW = 10;

    logic clock  = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    l2_port_arbiter_if #(.N(N), .AW(AW)) bus ();

`ifdef L2ARB_PERF_EN
    logic [15:0] grant_cnt_a, grant_cnt_b, contention_cnt;
`endif

    l2_port_arbiter #(.N(N), .AW(AW)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
`ifdef L2ARB_PERF_EN
        ,
        .grant_cnt_a    (grant_cnt_a),
        .grant_cnt_b    (grant_cnt_b),
        .contention_cnt (contention_cnt)
`endif
    );

    // req fields: bit0 = read, bit1 = write
    typedef struct {
        logic [1:0]    a_req;
        logic [1:0]    b_req;
        logic [AW-1:0] a_addr;
        logic [AW-1:0] b_addr;
        logic [N-1:0]  a_wdata;
        logic [N-1:0]  b_wdata;
        int            busy;
        logic [N-1:0]  rdata;
        core_id_t      exp_first;
    } vec_t;

    typedef struct {
        core_id_t      owner;
        op_t           op;
        logic [AW-1:0] addr;
        logic [N-1:0]  wdata;
        logic [N-1:0]  rdata;
        int            busy;
    } txn_t;

    vec_t  vecs [8];
    txn_t  q [$];
    txn_t  cur;
    bit    in_flight;
    bit    a_pend, b_pend;
    int    cyc, issue_cyc, busy_rem;
    int    n_checks, n_pass;
    int    m_ga, m_gb, m_cont;
    logic [N-1:0] exp_rd_a, exp_rd_b;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [127:0] all_outs();
        return {bus.l2_read_request, bus.l2_write_request, bus.l2_addr, bus.l2_wdata,
                bus.l1a_rdata, bus.l1b_rdata, bus.l1a_done, bus.l1b_done,
                bus.l2_busy_out_a, bus.l2_busy_out_b, bus.snoop_read_a, bus.snoop_write_a,
                bus.snoop_read_b, bus.snoop_write_b};
    endfunction

    // Called once per negedge: scoreboard compare plus the L2 response model
    task automatic mon();
        txn_t e;
        logic rd, wr, isw;
        cyc++;
        rd = bus.l2_read_request;
        wr = bus.l2_write_request;
        if (rd || wr) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_issue: got rd=%0b wr=%0b expected no request", rd, wr);
            end else begin
                e = q.pop_front();
                isw = (e.op == OP_WRITE);
                check("issue_op", {rd, wr}, isw ? 2'b01 : 2'b10);
                check("issue_addr", bus.l2_addr, e.addr);
                check("issue_wdata", bus.l2_wdata, e.wdata);
                check("issue_snoop",
                      {bus.snoop_read_a, bus.snoop_write_a, bus.snoop_read_b, bus.snoop_write_b},
                      (e.owner == CORE_A) ? {2'b00, !isw, isw} : {!isw, isw, 2'b00});
                if (e.owner == CORE_A) m_ga++; else m_gb++;
                cur = e;
                in_flight = 1'b1;
                issue_cyc = cyc;
                busy_rem = e.busy;
                bus.l2_busy_in  = 1'b1;
                bus.l2_rdata_in = 32'hBAD0BAD0;
            end
        end else if (bus.l1a_done || bus.l1b_done) begin
            if (!in_flight) begin
                n_checks++;
                $display("FAIL unexpected_done: got a=%0b b=%0b expected none",
                         bus.l1a_done, bus.l1b_done);
            end else begin
                check("done_owner", {bus.l1a_done, bus.l1b_done},
                      (cur.owner == CORE_A) ? 2'b10 : 2'b01);
                check("latency", cyc - issue_cyc, cur.busy + 2);
                if (cur.op == OP_READ && cur.owner == CORE_A) exp_rd_a = cur.rdata;
                if (cur.op == OP_READ && cur.owner == CORE_B) exp_rd_b = cur.rdata;
                check("rdata_a", bus.l1a_rdata, exp_rd_a);
                check("rdata_b", bus.l1b_rdata, exp_rd_b);
                check("done_busy_snoop",
                      {bus.l2_busy_out_a, bus.l2_busy_out_b, bus.snoop_read_a,
                       bus.snoop_write_a, bus.snoop_read_b, bus.snoop_write_b}, 6'b110000);
                in_flight = 1'b0;
                bus.l2_busy_in = 1'b0;
                if (cur.owner == CORE_A) begin
                    bus.l1a_read_req = 1'b0; bus.l1a_write_req = 1'b0; a_pend = 1'b0;
                end else begin
                    bus.l1b_read_req = 1'b0; bus.l1b_write_req = 1'b0; b_pend = 1'b0;
                end
            end
        end else if (in_flight) begin
            if (busy_rem > 0) begin
                busy_rem--;
                bus.l2_busy_in = 1'b1;
            end else begin
                bus.l2_busy_in  = 1'b0;
                bus.l2_rdata_in = cur.rdata;
            end
        end
    endtask

    task automatic run_until_idle(input string name, input int budget);
        for (int c = 0; c < budget && (a_pend || b_pend); c++) begin
            @(negedge clock);
            mon();
        end
        if (a_pend || b_pend) begin
            n_checks++;
            $display("FAIL %s_timeout: got pending a=%0b b=%0b expected both done", name, a_pend, b_pend);
        end
        check({name, "_queue_empty"}, q.size(), 0);
    endtask

    function automatic txn_t mk(input core_id_t o, input logic [1:0] req, input logic [AW-1:0] addr,
                                input logic [N-1:0] wd, input logic [N-1:0] rd, input int busy);
        txn_t t;
        t.owner = o;
        t.op    = req[1] ? OP_WRITE : OP_READ;
        t.addr  = addr;
        t.wdata = wd;
        t.rdata = rd;
        t.busy  = busy;
        return t;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        bit both;
        both = (v.a_req != 2'b00) && (v.b_req != 2'b00);
        if (both) begin
            m_cont++;
            if (v.exp_first == CORE_A) begin
                q.push_back(mk(CORE_A, v.a_req, v.a_addr, v.a_wdata, v.rdata, v.busy));
                q.push_back(mk(CORE_B, v.b_req, v.b_addr, v.b_wdata, ~v.rdata, v.busy));
            end else begin
                q.push_back(mk(CORE_B, v.b_req, v.b_addr, v.b_wdata, v.rdata, v.busy));
                q.push_back(mk(CORE_A, v.a_req, v.a_addr, v.a_wdata, ~v.rdata, v.busy));
            end
        end else if (v.a_req != 2'b00) begin
            q.push_back(mk(CORE_A, v.a_req, v.a_addr, v.a_wdata, v.rdata, v.busy));
        end else begin
            q.push_back(mk(CORE_B, v.b_req, v.b_addr, v.b_wdata, v.rdata, v.busy));
        end
        bus.l1a_read_req  = v.a_req[0];  bus.l1a_write_req = v.a_req[1];
        bus.l1b_read_req  = v.b_req[0];  bus.l1b_write_req = v.b_req[1];
        bus.l1a_addr = v.a_addr;  bus.l1a_wdata = v.a_wdata;
        bus.l1b_addr = v.b_addr;  bus.l1b_wdata = v.b_wdata;
        a_pend = (v.a_req != 2'b00);
        b_pend = (v.b_req != 2'b00);
        run_until_idle($sformatf("vec%0d", idx), 100);
    endtask

    initial begin
        vecs[0] = '{2'b10, 2'b10, 10'h001, 10'h002, 32'h11, 32'h22, 1, 32'h0, CORE_A};
        vecs[1] = '{2'b01, 2'b00, 10'h005, 10'h000, 32'h0, 32'h0, 2, 32'hDEADBEEF, CORE_A};
        vecs[2] = '{2'b00, 2'b11, 10'h000, 10'h3FF, 32'h0, 32'hCAFE0001, 0, 32'h0, CORE_B};
        vecs[3] = '{2'b01, 2'b01, 10'h010, 10'h020, 32'h0, 32'h0, 0, 32'h12345678, CORE_A};
        vecs[4] = '{2'b00, 2'b01, 10'h000, 10'h1A5, 32'h0, 32'h0, 3, 32'hA5A5A5A5, CORE_B};
        vecs[5] = '{2'b10, 2'b00, 10'h0AA, 10'h000, 32'h55, 32'h0, 0, 32'h0, CORE_A};
        vecs[6] = '{2'b01, 2'b10, 10'h3C3, 10'h0F0, 32'h0, 32'h77, 1, 32'h0F0F0F0F, CORE_B};
        vecs[7] = '{2'b11, 2'b01, 10'h100, 10'h200, 32'h99, 32'h0, 2, 32'h13579BDF, CORE_B};

        bus.l1a_read_req = 0; bus.l1a_write_req = 0; bus.l1b_read_req = 0; bus.l1b_write_req = 0;
        bus.l1a_addr = '0; bus.l1b_addr = '0; bus.l1a_wdata = '0; bus.l1b_wdata = '0;
        bus.l2_busy_in = 1'b0; bus.l2_rdata_in = '0;
        exp_rd_a = '0; exp_rd_b = '0;

        // Reset, then idle with no requests
        repeat (3) @(negedge clock);
        nreset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            cyc++;
            check("idle_outputs_zero", all_outs(), '0);
        end

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // A read dropped by the L1 right after grant still completes
        q.push_back(mk(CORE_A, 2'b01, 10'h2AB, 32'h3, 32'h600DF00D, 1));
        bus.l1a_read_req = 1'b1; bus.l1a_addr = 10'h2AB; bus.l1a_wdata = 32'h3;
        a_pend = 1'b1;
        for (int c = 0; c < 20 && !in_flight; c++) begin
            @(negedge clock);
            mon();
        end
        bus.l1a_read_req = 1'b0;
        bus.l1a_addr = '0;
        run_until_idle("early_drop", 50);

`ifdef L2ARB_PERF_EN
        check("grant_cnt_a", grant_cnt_a, m_ga);
        check("grant_cnt_b", grant_cnt_b, m_gb);
        check("contention_cnt", contention_cnt, m_cont);
        @(negedge clock);
        force dut.r_grant_cnt_b = 16'hFFFF;
        @(negedge clock);
        release dut.r_grant_cnt_b;
        q.push_back(mk(CORE_B, 2'b10, 10'h0B0, 32'hB0, 32'h0, 0));
        bus.l1b_write_req = 1'b1; bus.l1b_addr = 10'h0B0; bus.l1b_wdata = 32'hB0;
        b_pend = 1'b1;
        run_until_idle("wrap", 30);
        check("grant_cnt_b_wrap", grant_cnt_b, 16'h0000);
`endif

        // Reset while in WAIT abandons the transaction
        q.push_back(mk(CORE_A, 2'b01, 10'h077, 32'h0, 32'h0, 20));
        bus.l1a_read_req = 1'b1; bus.l1a_addr = 10'h077; bus.l1a_wdata = 32'h0;
        a_pend = 1'b1;
        for (int c = 0; c < 30 && !(in_flight && (cyc - issue_cyc) >= 2); c++) begin
            @(negedge clock);
            mon();
        end
        check("reached_wait", {in_flight, bus.l2_busy_out_a}, 2'b11);
        nreset = 1'b0;
        bus.l1a_read_req = 1'b0;
        bus.l2_busy_in = 1'b0;
        q.delete();
        in_flight = 1'b0;
        a_pend = 1'b0;
        exp_rd_a = '0;
        exp_rd_b = '0;
        @(negedge clock);
        cyc++;
        check("reset_mid_wait_outputs", all_outs(), '0);
        nreset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            mon();
            check("no_done_after_reset", {bus.l1a_done, bus.l1b_done, bus.l2_busy_out_a}, 3'b000);
        end
        run_vec('{2'b00, 2'b10, 10'h000, 10'h155, 32'h0, 32'hABCD, 1, 32'h0, CORE_B}, 100);
        run_vec('{2'b01, 2'b01, 10'h011, 10'h022, 32'h0, 32'h0, 0, 32'h2468ACE0, CORE_A}, 101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
